jtag_cfg_loader: RTL and testbench
==================================

Name: jtag_cfg_loader

Overview:
- Sits between the JTAG config data register in jtag_top and the FIR coefficient register file, in the TCK domain.
- Takes each completed 8-bit config update, hunts for the sync word, then parses frames of the form header (start address), length, then data bytes.
- Issues one coefficient write per data byte, with an auto-incrementing, wrapping address.
- iDesync drops it back to hunting.

Parameters:
- DATA_W, 8, width of config bytes and coefficients.
- NUM_TAPS, 16, number of coefficient registers; address wraps modulo NUM_TAPS.
- ADDR_W, 4, coefficient address width; must be at least clog2(NUM_TAPS).
- SYNC_WORD, 8'hF0, byte value that establishes sync.

Ports:
- iTck  in  1  config clock (JTAG TCK).
- iTrst  in  1  asynchronous active-low reset.
- iByteValid  in  1  one-cycle strobe: iByte holds a completed config update (driven from jtag_top oWrEn).
- iByte  in  DATA_W  config byte, valid when iByteValid is high.
- iDesync  in  1  one-cycle desync request.
- oCoefWrEn  out  1  coefficient write strobe.
- oCoefAddr  out  ADDR_W  coefficient address.
- oCoefData  out  DATA_W  coefficient value.
- oSynced  out  1  high from sync detect until desync or reset.
- oBusy  out  1  high while a frame's LEN/DATA/CHECK bytes are outstanding.
- oCfgDone  out  1  one-cycle pulse when a frame completes successfully.
- oCfgErr  out  1  sticky frame-error flag.
- oWordCnt  out  8  number of coefficient writes issued since the last sync.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (iTrst low). While iTrst is low:
  - all outputs are 0;
  - FSM is in HUNT;
  - internal address, remaining-count and checksum registers are 0.
  - Reset mid-frame abandons the frame; no partial pulse is issued.
- FSM states: HUNT, HEADER, LEN, DATA, CHECK (CHECK exists only with the optional feature). All transitions happen on iByteValid unless noted.
- HUNT:
  - iByte == SYNC_WORD -> HEADER; oSynced set; oCfgErr cleared; oWordCnt cleared.
  - Any other byte is ignored.
- HEADER:
  - iByte[ADDR_W-1:0] modulo NUM_TAPS is loaded as the start address; oBusy set; next state LEN.
  - A byte equal to SYNC_WORD is treated as an ordinary header (no re-sync).
- LEN:
  - iByte is the coefficient count N.
  - N == 0: frame ends immediately and oBusy clears. Without checksum, oCfgDone pulses and the FSM returns to HEADER. With checksum, the FSM goes to CHECK.
  - N > 0: next state DATA.
- DATA:
  - Each byte produces oCoefWrEn = 1 for exactly one cycle, registered, on the cycle after iByteValid. oCoefAddr is the current address and oCoefData is the byte.
  - After each write: address increments, wrapping from NUM_TAPS-1 to 0; remaining count decrements; oWordCnt increments, saturating at 255.
  - N > NUM_TAPS is legal; later writes overwrite earlier ones.
  - After the Nth byte: without checksum, oCfgDone pulses in the same cycle as the last oCoefWrEn, oBusy clears, and the FSM returns to HEADER. With checksum, the FSM goes to CHECK.
- Frames may follow back-to-back without re-sync.
- iDesync:
  - Forces HUNT from any state and clears oSynced, oBusy and the remaining count.
  - Takes priority over a simultaneous iByteValid; that byte is dropped.
  - iDesync while in DATA mid-frame sets oCfgErr (truncated frame).
- iByteValid held high for consecutive cycles: each cycle is a separate byte.
- Outputs are all registered; no combinational path from input to output.

Optional Feature:
- Macro: CFG_CHECKSUM_EN.
- Defined:
  - A running XOR is reset on HEADER entry and accumulates the header, LEN and all data bytes.
  - CHECK state: the next byte is compared with the accumulated XOR.
  - Match: oCfgDone pulses.
  - Mismatch: oCfgErr is set, no oCfgDone.
  - Either way oBusy clears and the FSM returns to HEADER.
  - Coefficient writes are not rolled back.
- Undefined: no CHECK state, no checksum logic; a frame ends after its last data byte.

Test Plan:
- Reset, then bytes 0x00, 0x3C, then 0xF0 -> no writes before the sync byte; oSynced = 1 after 0xF0; oCfgErr = 0.
- After sync: header 0x02, LEN 0x03, data 0x11, 0x22, 0x33 -> writes (2,0x11), (3,0x22), (4,0x33), each one cycle after its strobe; oCfgDone pulses with the third write; oWordCnt = 3.
- After sync: header 0x0E, LEN 0x04, data 0xA0..0xA3 -> addresses 14, 15, 0, 1 (wrap).
- During DATA with 2 of 4 bytes sent: iDesync asserted in the same cycle as iByteValid -> that byte is not written; oCfgErr = 1; oSynced = 0; the next 0xF0 clears oCfgErr.
- With CFG_CHECKSUM_EN: header 0x00, LEN 0x01, data 0x55, check 0x54 -> oCfgDone pulses. Repeat with check 0x00 -> oCfgErr = 1, no oCfgDone, write to address 0 still issued.
- iTrst pulsed low mid-DATA -> all outputs 0 immediately; FSM in HUNT; header-like bytes after release are ignored until 0xF0.

Source files
------------

// File: rtl/jtag_cfg_loader_if.sv
// Byte channel from the JTAG config register into the loader, plus the
// coefficient write bus it drives toward the FIR coefficient register file.
interface jtag_cfg_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              iByteValid;
    logic [DATA_W-1:0] iByte;
    logic              iDesync;
    logic              oCoefWrEn;
    logic [ADDR_W-1:0] oCoefAddr;
    logic [DATA_W-1:0] oCoefData;

    modport master (
        output iByteValid, iByte, iDesync,
        input  oCoefWrEn, oCoefAddr, oCoefData
    );

    modport slave (
        input  iByteValid, iByte, iDesync,
        output oCoefWrEn, oCoefAddr, oCoefData
    );
endinterface

// File: rtl/jtag_cfg_loader.sv
// JTAG config byte-stream parser: sync hunt, then header/length/data frames
// turned into coefficient writes. Define CFG_CHECKSUM_EN for the trailing XOR check byte.
module jtag_cfg_loader #(
    parameter int               DATA_W    = 8,
    parameter int               NUM_TAPS  = 16,
    parameter int               ADDR_W    = 4,
    parameter logic [DATA_W-1:0] SYNC_WORD = 8'hF0
) (
    input  logic                 iTck,
    input  logic                 iTrst,
    jtag_cfg_loader_if.slave     bus,
    output logic                 oSynced,
    output logic                 oBusy,
    output logic                 oCfgDone,
    output logic                 oCfgErr,
    output logic [7:0]           oWordCnt
);

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_HEADER = 3'd1,
        ST_LEN    = 3'd2,
`ifdef CFG_CHECKSUM_EN
        ST_CHECK  = 3'd4,
`endif
        ST_DATA   = 3'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        rem_q, rem_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              synced_q, synced_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
`ifdef CFG_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] b);
        logic [31:0] raw;
        raw = 32'(b[ADDR_W-1:0]);
        raw = raw % 32'(NUM_TAPS);
        return raw[ADDR_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        if (32'(a) == 32'(NUM_TAPS - 1)) begin
            r = {ADDR_W{1'b0}};
        end else begin
            r = a + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        logic [7:0] r;
        if (c == 8'hFF) begin
            r = c;
        end else begin
            r = c + 8'd1;
        end
        return r;
    endfunction

    // Next-state and registered-output decode; desync overrides any byte in the same cycle.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        synced_d  = synced_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        cnt_d     = cnt_q;
`ifdef CFG_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        if (bus.iDesync) begin
            state_d  = ST_HUNT;
            synced_d = 1'b0;
            busy_d   = 1'b0;
            rem_d    = 8'd0;
            if (state_q == ST_DATA) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else if (bus.iByteValid) begin
            case (state_q)
                ST_HUNT: begin
                    if (bus.iByte == SYNC_WORD) begin
                        state_d  = ST_HEADER;
                        synced_d = 1'b1;
                        err_d    = 1'b0;
                        cnt_d    = 8'd0;
                    end else begin
                        state_d  = ST_HUNT;
                    end
                end
                ST_HEADER: begin
                    addr_d  = hdr_addr(bus.iByte);
                    busy_d  = 1'b1;
                    state_d = ST_LEN;
`ifdef CFG_CHECKSUM_EN
                    csum_d  = bus.iByte;
`endif
                end
                ST_LEN: begin
                    rem_d = 8'(bus.iByte);
`ifdef CFG_CHECKSUM_EN
                    csum_d = csum_q ^ bus.iByte;
`endif
                    if (bus.iByte == {DATA_W{1'b0}}) begin
`ifdef CFG_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_HEADER;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = bus.iByte;
                    addr_d    = next_addr(addr_q);
                    rem_d     = rem_q - 8'd1;
                    cnt_d     = sat_inc(cnt_q);
`ifdef CFG_CHECKSUM_EN
                    csum_d    = csum_q ^ bus.iByte;
`endif
                    if (rem_q == 8'd1) begin
`ifdef CFG_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_HEADER;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
`ifdef CFG_CHECKSUM_EN
                // Writes already issued stand even when the check byte disagrees.
                ST_CHECK: begin
                    busy_d  = 1'b0;
                    state_d = ST_HEADER;
                    if (bus.iByte == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers, cleared asynchronously by the TAP reset.
    always_ff @(posedge iTck or negedge iTrst) begin
        if (!iTrst) begin
            state_q   <= ST_HUNT;
            addr_q    <= {ADDR_W{1'b0}};
            rem_q     <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
            synced_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
`ifdef CFG_CHECKSUM_EN
            csum_q    <= {DATA_W{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            synced_q  <= synced_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`ifdef CFG_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign bus.oCoefWrEn = wr_en_q;
    assign bus.oCoefAddr = wr_addr_q;
    assign bus.oCoefData = wr_data_q;
    assign oSynced       = synced_q;
    assign oBusy         = busy_q;
    assign oCfgDone      = done_q;
    assign oCfgErr       = err_q;
    assign oWordCnt      = cnt_q;

endmodule

// File: tb/tb_jtag_cfg_loader.sv
// Scoreboard bench for jtag_cfg_loader: stimulus pushes expected write/done events,
// a negedge monitor pops and compares them; status flags are checked inline.
module tb_jtag_cfg_loader;

    typedef struct packed {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic       done;
    } ev_t;

    logic       iTck;
    logic       iTrst;
    logic       oSynced, oBusy, oCfgDone, oCfgErr;
    logic [7:0] oWordCnt;
    ev_t        exp_q[$];
    logic [7:0] dbuf [0:7];
    int         n_vec;
    int         n_err;

    jtag_cfg_loader_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    jtag_cfg_loader #(.DATA_W(8), .NUM_TAPS(16), .ADDR_W(4), .SYNC_WORD(8'hF0)) dut (
        .iTck     (iTck),
        .iTrst    (iTrst),
        .bus      (bus),
        .oSynced  (oSynced),
        .oBusy    (oBusy),
        .oCfgDone (oCfgDone),
        .oCfgErr  (oCfgErr),
        .oWordCnt (oWordCnt)
    );

    initial iTck = 1'b0;
    always #5 iTck = ~iTck;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every write or done pulse must match the oldest expected event.
    always @(negedge iTck) begin
        if (iTrst && (bus.oCoefWrEn || oCfgDone)) begin
            n_vec = n_vec + 1;
            if (exp_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL unexpected_event: wr=%0b addr=%0d data=0x%0h done=%0b, none expected",
                         bus.oCoefWrEn, bus.oCoefAddr, bus.oCoefData, oCfgDone);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (bus.oCoefWrEn !== e.wr || oCfgDone !== e.done ||
                    (e.wr && (bus.oCoefAddr !== e.addr || bus.oCoefData !== e.data))) begin
                    n_err = n_err + 1;
                    $display("FAIL event: got wr=%0b addr=%0d data=0x%0h done=%0b expected wr=%0b addr=%0d data=0x%0h done=%0b",
                             bus.oCoefWrEn, bus.oCoefAddr, bus.oCoefData, oCfgDone,
                             e.wr, e.addr, e.data, e.done);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bus.iByteValid = 1'b1;
        bus.iByte      = b;
        @(posedge iTck);
        #1;
        bus.iByteValid = 1'b0;
        bus.iByte      = 8'h00;
    endtask

    task automatic send_desync(input logic [7:0] b);
        bus.iDesync    = 1'b1;
        bus.iByteValid = 1'b1;
        bus.iByte      = b;
        @(posedge iTck);
        #1;
        bus.iDesync    = 1'b0;
        bus.iByteValid = 1'b0;
        bus.iByte      = 8'h00;
    endtask

    task automatic push(input logic wr, input logic [3:0] a, input logic [7:0] d, input logic dn);
        ev_t e;
        e.wr = wr; e.addr = a; e.data = d; e.done = dn;
        exp_q.push_back(e);
    endtask

    // Complete frame from dbuf; appends the XOR check byte when that feature is built.
    task automatic frame(input logic [7:0] hdr, input int n);
        logic [7:0] x;
        logic [3:0] a;
        logic       last_done;
        a = hdr[3:0];
        x = hdr ^ 8'(n);
`ifdef CFG_CHECKSUM_EN
        last_done = 1'b0;
`else
        last_done = 1'b1;
        if (n == 0) push(1'b0, 4'd0, 8'h00, 1'b1);
`endif
        send(hdr);
        send(8'(n));
        for (int i = 0; i < n; i++) begin
            push(1'b1, a, dbuf[i], (i == n - 1) ? last_done : 1'b0);
            send(dbuf[i]);
            x = x ^ dbuf[i];
            a = a + 4'd1;
        end
`ifdef CFG_CHECKSUM_EN
        push(1'b0, 4'd0, 8'h00, 1'b1);
        send(x);
`endif
        chk("frame_busy_clear", {31'd0, oBusy}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        iTrst = 1'b0;
        bus.iByteValid = 1'b0;
        bus.iByte      = 8'h00;
        bus.iDesync    = 1'b0;
        repeat (3) @(posedge iTck);
        #1;
        chk("reset_outputs", {19'd0, bus.oCoefWrEn, bus.oCoefAddr, bus.oCoefData, oCfgDone, oCfgErr, oSynced, oBusy},
            32'd0);
        chk("reset_wordcnt", {24'd0, oWordCnt}, 32'd0);
        iTrst = 1'b1;
        @(posedge iTck);
        #1;

        // Hunt: only the sync word is accepted.
        send(8'h00);
        send(8'h3C);
        chk("hunt_not_synced", {31'd0, oSynced}, 32'd0);
        send(8'hF0);
        chk("sync_synced", {31'd0, oSynced}, 32'd1);
        chk("sync_err", {31'd0, oCfgErr}, 32'd0);

        dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33;
        frame(8'h02, 3);
        chk("wordcnt_3", {24'd0, oWordCnt}, 32'd3);

        dbuf[0] = 8'hA0; dbuf[1] = 8'hA1; dbuf[2] = 8'hA2; dbuf[3] = 8'hA3;
        frame(8'h0E, 4);
        chk("wordcnt_7", {24'd0, oWordCnt}, 32'd7);

        frame(8'h05, 0);
        chk("zero_len_wordcnt", {24'd0, oWordCnt}, 32'd7);

        // A sync-valued byte in header position is just address 0.
        dbuf[0] = 8'h77;
        frame(8'hF0, 1);
        chk("f0_header_synced", {31'd0, oSynced}, 32'd1);
        chk("wordcnt_8", {24'd0, oWordCnt}, 32'd8);
        chk("no_err_yet", {31'd0, oCfgErr}, 32'd0);

        // Desync mid-DATA drops the coincident byte and flags truncation.
        send(8'h04);
        chk("header_busy", {31'd0, oBusy}, 32'd1);
        send(8'h04);
        push(1'b1, 4'd4, 8'hB0, 1'b0);
        send(8'hB0);
        push(1'b1, 4'd5, 8'hB1, 1'b0);
        send(8'hB1);
        chk("wordcnt_10", {24'd0, oWordCnt}, 32'd10);
        send_desync(8'hB2);
        chk("desync_err", {31'd0, oCfgErr}, 32'd1);
        chk("desync_synced", {31'd0, oSynced}, 32'd0);
        chk("desync_busy", {31'd0, oBusy}, 32'd0);
        send(8'h0A);
        send(8'hF0);
        chk("resync_err_clr", {31'd0, oCfgErr}, 32'd0);
        chk("resync_synced", {31'd0, oSynced}, 32'd1);
        chk("resync_wordcnt", {24'd0, oWordCnt}, 32'd0);

`ifdef CFG_CHECKSUM_EN
        dbuf[0] = 8'h55;
        frame(8'h00, 1);
        chk("csum_ok_err", {31'd0, oCfgErr}, 32'd0);
        send(8'h00);
        send(8'h01);
        push(1'b1, 4'd0, 8'h55, 1'b0);
        send(8'h55);
        send(8'h00);
        chk("csum_bad_err", {31'd0, oCfgErr}, 32'd1);
        chk("csum_bad_busy", {31'd0, oBusy}, 32'd0);
`endif

        // Reset in the middle of DATA, after the first write has been observed.
        send(8'h03);
        send(8'h05);
        push(1'b1, 4'd3, 8'hC0, 1'b0);
        send(8'hC0);
        @(negedge iTck);
        #1;
        iTrst = 1'b0;
        #1;
        chk("midreset_outputs", {19'd0, bus.oCoefWrEn, bus.oCoefAddr, bus.oCoefData, oCfgDone, oCfgErr, oSynced, oBusy},
            32'd0);
        chk("midreset_wordcnt", {24'd0, oWordCnt}, 32'd0);
        @(posedge iTck);
        #1;
        iTrst = 1'b1;
        send(8'h02);
        send(8'h03);
        send(8'h11);
        chk("post_reset_hunt", {31'd0, oSynced}, 32'd0);
        send(8'hF0);
        dbuf[0] = 8'h99;
        frame(8'h01, 1);
        chk("post_reset_wordcnt", {24'd0, oWordCnt}, 32'd1);

        repeat (3) @(posedge iTck);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
